conv_window_stream: RTL and testbench

//  Streaming K x K x C sliding-window generator for the conv datapath; successor to the full-frame window buffer.

---
 rtl/conv_pkg.sv | 35 +++
 rtl/lb_row_ring.sv | 85 ++++++++
 rtl/conv_window_stream.sv | 205 ++++++++++++++++++++
 tb/tb_conv_window_stream.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution window generator
// and the MAC array that consumes its windows.
package conv_pkg;

    // Window generator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

    // Ceiling log2, never below 1 so that every counter keeps at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Output dimension of a padded, strided K x K convolution.
    function automatic int out_dim(input int w, input int p, input int k, input int s);
        return (w + 32'sd2 * p - k) / s + 32'sd1;
    endfunction

    // Element slot of (channel c, kernel row m, kernel col n) inside a packed window.
    function automatic int elem_idx(input int c, input int m, input int n, input int k);
        return c * k * k + m * k + n;
    endfunction

endpackage

// File: rtl/lb_row_ring.sv
// Circular store of KERNEL_SIZE image rows with one pixel write port and a
// combinational K x K window read. Padded coordinates that fall outside the
// image produce zeros and never touch the store.
module lb_row_ring
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = 6,
    parameter int IMG_HEIGHT  = 6,
    parameter int CHANNELS    = 3,
    parameter int KERNEL_SIZE = 3,
    parameter int PADDING     = 1,
    parameter int DATA_WIDTH  = 8,
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int SLOT_W      = 2,
    parameter int X_W         = 3
) (
    input  logic                                                    clk,
    input  logic                                                    wr_en,
    input  logic [SLOT_W-1:0]                                       wr_slot,
    input  logic [X_W-1:0]                                          wr_col,
    input  logic [DATA_WIDTH*CHANNELS-1:0]                          wr_data,
    input  logic [ROW_W-1:0]                                        rd_row,
    input  logic [COL_W-1:0]                                        rd_col,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNELS-1:0]  rd_window
);

    localparam int PIX_W = DATA_WIDTH * CHANNELS;

    logic [PIX_W-1:0]  row_mem_r [KERNEL_SIZE][IMG_WIDTH];

    logic [ROW_W-1:0]  py_s;
    logic [COL_W-1:0]  px_s;
    logic [ROW_W-1:0]  iy_s;
    logic [SLOT_W-1:0] slot_s;
    logic [X_W-1:0]    ix_s;
    logic              row_ok_s;
    logic              col_ok_s;
    logic [PIX_W-1:0]  pix_s;

    // Store one popped pixel into its row slot; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            row_mem_r[wr_slot][wr_col] <= wr_data;
        end
    end

    // Gather the K x K window anchored at padded (rd_row, rd_col), zero outside the image.
    always_comb begin
        rd_window = '0;
        py_s      = '0;
        px_s      = '0;
        iy_s      = '0;
        slot_s    = '0;
        ix_s      = '0;
        row_ok_s  = 1'b0;
        col_ok_s  = 1'b0;
        pix_s     = '0;
        for (int m = 0; m < KERNEL_SIZE; m++) begin
            for (int n = 0; n < KERNEL_SIZE; n++) begin
                py_s     = rd_row + ROW_W'(m);
                px_s     = rd_col + COL_W'(n);
                row_ok_s = (py_s >= ROW_W'(PADDING)) && (py_s < ROW_W'(IMG_HEIGHT + PADDING));
                col_ok_s = (px_s >= COL_W'(PADDING)) && (px_s < COL_W'(IMG_WIDTH + PADDING));
                iy_s     = py_s - ROW_W'(PADDING);
                slot_s   = SLOT_W'(iy_s % ROW_W'(KERNEL_SIZE));
                if (col_ok_s) begin
                    ix_s = X_W'(px_s - COL_W'(PADDING));
                end else begin
                    ix_s = '0;
                end
                if (row_ok_s && col_ok_s) begin
                    pix_s = row_mem_r[slot_s][ix_s];
                end else begin
                    pix_s = '0;
                end
                for (int c = 0; c < CHANNELS; c++) begin
                    rd_window[elem_idx(c, m, n, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                        pix_s[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_stream.sv
// Streaming K x K x C sliding-window generator. Pops raster-order pixels from a
// first-word-fall-through FIFO into a K-row ring, then emits every window of an
// output row over valid/ready before fetching the rows the next output row needs.
module conv_window_stream
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH   = 6,
    parameter int IMG_HEIGHT  = 6,
    parameter int CHANNELS    = 3,
    parameter int KERNEL_SIZE = 3,
    parameter int PADDING     = 1,
    parameter int STRIDE      = 1,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    output logic                                                    fifo_read_en,
    input  logic [DATA_WIDTH*CHANNELS-1:0]                          fifo_data,
    input  logic                                                    fifo_empty,
    output logic                                                    window_valid,
    output logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE*CHANNELS-1:0]  window_data,
    input  logic                                                    window_ready,
    output logic                                                    frame_done,
    output logic                                                    busy
);

    localparam int OUT_W    = out_dim(IMG_WIDTH, PADDING, KERNEL_SIZE, STRIDE);
    localparam int OUT_H    = out_dim(IMG_HEIGHT, PADDING, KERNEL_SIZE, STRIDE);
    localparam int WIN_W    = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE * CHANNELS;
    localparam int ROW_W    = clog2(IMG_HEIGHT + 2 * PADDING + KERNEL_SIZE + 1);
    localparam int COL_W    = clog2(IMG_WIDTH + 2 * PADDING + KERNEL_SIZE + 1);
    localparam int SLOT_W   = clog2(KERNEL_SIZE);
    localparam int X_W      = clog2(IMG_WIDTH);
    localparam int WR_ROW_W = clog2(IMG_HEIGHT + 1);
    localparam int OC_W     = clog2(OUT_W + 1);
    localparam int OR_W     = clog2(OUT_H + 1);

    localparam logic [ROW_W-1:0]  KMP_C       = ROW_W'(KERNEL_SIZE - PADDING);
    localparam logic [ROW_W-1:0]  H_C         = ROW_W'(IMG_HEIGHT);
    localparam logic [ROW_W-1:0]  S_ROW_C     = ROW_W'(STRIDE);
    localparam logic [COL_W-1:0]  S_COL_C     = COL_W'(STRIDE);
    localparam logic [X_W-1:0]    LAST_X_C    = X_W'(IMG_WIDTH - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT_C = SLOT_W'(KERNEL_SIZE - 1);
    localparam logic [OC_W-1:0]   LAST_OC_C   = OC_W'(OUT_W - 1);
    localparam logic [OR_W-1:0]   LAST_OR_C   = OR_W'(OUT_H - 1);

    state_e              state_r;
    logic [WR_ROW_W-1:0] wr_row_r;     // image rows completely stored this frame
    logic [X_W-1:0]      wr_col_r;
    logic [SLOT_W-1:0]   wr_slot_r;    // ring slot of the row being written
    logic [ROW_W-1:0]    top_row_r;    // padded row of the current output row's windows
    logic [COL_W-1:0]    left_col_r;   // padded column of the window in window_data_r
    logic [OR_W-1:0]     out_row_r;
    logic [OC_W-1:0]     out_col_r;
    logic                window_valid_r;
    logic [WIN_W-1:0]    window_data_r;
    logic                frame_done_r;
    logic                busy_r;

    logic [ROW_W-1:0]    need_raw_s;
    logic [ROW_W-1:0]    need_rows_s;
    logic                rows_ready_s;
    logic                pop_s;
    logic [COL_W-1:0]    rd_col_s;
    logic [WIN_W-1:0]    ring_window_s;

    // Rows the current output row needs, capped at the image height for bottom padding.
    always_comb begin
        need_raw_s = top_row_r + KMP_C;
        if (need_raw_s > H_C) begin
            need_rows_s = H_C;
        end else begin
            need_rows_s = need_raw_s;
        end
        rows_ready_s = (ROW_W'(wr_row_r) >= need_rows_s);
    end

    // Pop only while filling and only until the needed rows are present.
    always_comb begin
        pop_s = (state_r == FILL) && !fifo_empty && !rows_ready_s;
    end

    // Read address looks one window ahead once a window is already presented,
    // so the next window loads on the same edge the current one is accepted.
    always_comb begin
        if (window_valid_r) begin
            rd_col_s = left_col_r + S_COL_C;
        end else begin
            rd_col_s = left_col_r;
        end
    end

    lb_row_ring #(
        .IMG_WIDTH   (IMG_WIDTH),
        .IMG_HEIGHT  (IMG_HEIGHT),
        .CHANNELS    (CHANNELS),
        .KERNEL_SIZE (KERNEL_SIZE),
        .PADDING     (PADDING),
        .DATA_WIDTH  (DATA_WIDTH),
        .ROW_W       (ROW_W),
        .COL_W       (COL_W),
        .SLOT_W      (SLOT_W),
        .X_W         (X_W)
    ) u_ring (
        .clk       (clk),
        .wr_en     (pop_s),
        .wr_slot   (wr_slot_r),
        .wr_col    (wr_col_r),
        .wr_data   (fifo_data),
        .rd_row    (top_row_r),
        .rd_col    (rd_col_s),
        .rd_window (ring_window_s)
    );

    // Frame sequencing: fill rows, emit one output row of windows, repeat, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            wr_row_r       <= '0;
            wr_col_r       <= '0;
            wr_slot_r      <= '0;
            top_row_r      <= '0;
            left_col_r     <= '0;
            out_row_r      <= '0;
            out_col_r      <= '0;
            window_valid_r <= 1'b0;
            window_data_r  <= '0;
            frame_done_r   <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_done_r <= 1'b0;
                    if (!fifo_empty) begin
                        state_r    <= FILL;
                        wr_row_r   <= '0;
                        wr_col_r   <= '0;
                        wr_slot_r  <= '0;
                        top_row_r  <= '0;
                        left_col_r <= '0;
                        out_row_r  <= '0;
                        out_col_r  <= '0;
                    end
                end
                FILL: begin
                    if (rows_ready_s) begin
                        state_r    <= EMIT;
                        left_col_r <= '0;
                        out_col_r  <= '0;
                    end else if (pop_s) begin
                        busy_r <= 1'b1;
                        if (wr_col_r == LAST_X_C) begin
                            wr_col_r <= '0;
                            wr_row_r <= wr_row_r + WR_ROW_W'(1);
                            if (wr_slot_r == LAST_SLOT_C) begin
                                wr_slot_r <= '0;
                            end else begin
                                wr_slot_r <= wr_slot_r + SLOT_W'(1);
                            end
                        end else begin
                            wr_col_r <= wr_col_r + X_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (!window_valid_r) begin
                        window_data_r  <= ring_window_s;
                        window_valid_r <= 1'b1;
                    end else if (window_ready) begin
                        if (out_col_r == LAST_OC_C) begin
                            window_valid_r <= 1'b0;
                            if (out_row_r == LAST_OR_C) begin
                                state_r      <= DONE;
                                frame_done_r <= 1'b1;
                                busy_r       <= 1'b0;
                            end else begin
                                state_r   <= FILL;
                                out_row_r <= out_row_r + OR_W'(1);
                                top_row_r <= top_row_r + S_ROW_C;
                            end
                        end else begin
                            window_data_r <= ring_window_s;
                            out_col_r     <= out_col_r + OC_W'(1);
                            left_col_r    <= left_col_r + S_COL_C;
                        end
                    end
                end
                DONE: begin
                    frame_done_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign fifo_read_en = pop_s;
    assign window_valid = window_valid_r;
    assign window_data  = window_data_r;
    assign frame_done   = frame_done_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_conv_window_stream.sv
// Self-checking bench: a FIFO model feeds raster pixels, windows accepted on the
// handshake are compared against windows computed directly from padded coordinates.
module tb_conv_window_stream;

    localparam int W    = 6;
    localparam int H    = 6;
    localparam int C    = 3;
    localparam int K    = 3;
    localparam int P    = 1;
    localparam int DW   = 8;
    localparam int PIXW = DW * C;
    localparam int WINW = DW * K * K * C;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            rd_en0, rd_en1, empty0, empty1, valid0, valid1;
    logic            ready0, ready1, done0, done1, busy0, busy1;
    logic [PIXW-1:0] fifo_data;
    logic [WINW-1:0] wdata0, wdata1;

    conv_window_stream #(.STRIDE(1)) u_dut_s1 (
        .clk(clk), .rst_n(rst_n), .fifo_read_en(rd_en0), .fifo_data(fifo_data),
        .fifo_empty(empty0), .window_valid(valid0), .window_data(wdata0),
        .window_ready(ready0), .frame_done(done0), .busy(busy0)
    );

    conv_window_stream #(.STRIDE(2)) u_dut_s2 (
        .clk(clk), .rst_n(rst_n), .fifo_read_en(rd_en1), .fifo_data(fifo_data),
        .fifo_empty(empty1), .window_valid(valid1), .window_data(wdata1),
        .window_ready(ready1), .frame_done(done1), .busy(busy1)
    );

    int sel;
    logic            rd_en_sel, empty_sel, valid_sel, ready_sel, done_sel, busy_sel;
    logic [WINW-1:0] wdata_sel;
    assign rd_en_sel = (sel != 0) ? rd_en1 : rd_en0;
    assign empty_sel = (sel != 0) ? empty1 : empty0;
    assign valid_sel = (sel != 0) ? valid1 : valid0;
    assign ready_sel = (sel != 0) ? ready1 : ready0;
    assign done_sel  = (sel != 0) ? done1  : done0;
    assign busy_sel  = (sel != 0) ? busy1  : busy0;
    assign wdata_sel = (sel != 0) ? wdata1 : wdata0;

    logic [PIXW-1:0] fifo_q[$];
    logic [WINW-1:0] got_q[$];
    logic [WINW-1:0] exp_q[$];
    logic [PIXW-1:0] dummy_pix;
    logic [WINW-1:0] prev_data;
    logic            pop_pending, prev_stall, busy_seen, empty_s, ready_s;
    int gap_mode, ready_mode, cyc, frame_cnt, pop_viol, stall_viol, first_done_qsz;
    int n_checks = 0;
    int n_pass   = 0;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_eq(input string tag, input logic [WINW-1:0] obs, input logic [WINW-1:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pix_val(input int y, input int x, input int c, input int off);
        if (y < 0 || y >= H || x < 0 || x >= W) return '0;
        return DW'(16 * y + x + 64 * c + off);
    endfunction

    function automatic logic [DW-1:0] elem_of(input logic [WINW-1:0] w, input int c, input int m, input int n);
        return w[(c * K * K + m * K + n) * DW +: DW];
    endfunction

    task automatic push_frame(input int off);
        logic [PIXW-1:0] p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                for (int c = 0; c < C; c++) p[c*DW +: DW] = pix_val(y, x, c, off);
                fifo_q.push_back(p);
            end
        end
    endtask

    // Reference windows straight from padded-coordinate arithmetic.
    task automatic expect_frame(input int s, input int off);
        logic [WINW-1:0] win;
        int od;
        od = (W + 2 * P - K) / s + 1;
        for (int r = 0; r < od; r++) begin
            for (int q = 0; q < od; q++) begin
                for (int c = 0; c < C; c++)
                    for (int m = 0; m < K; m++)
                        for (int n = 0; n < K; n++)
                            win[(c * K * K + m * K + n) * DW +: DW] =
                                pix_val(r * s + m - P, q * s + n - P, c, off);
                exp_q.push_back(win);
            end
        end
    endtask

    task automatic clear_board();
        got_q.delete();
        exp_q.delete();
        frame_cnt = 0; pop_viol = 0; stall_viol = 0; first_done_qsz = -1;
        prev_stall = 1'b0; busy_seen = 1'b0;
    endtask

    // One clock of FIFO/consumer modelling and observation, sampled 1ns after the falling edge.
    task automatic tick();
        @(negedge clk);
        if (pop_pending && fifo_q.size() > 0) dummy_pix = fifo_q.pop_front();
        pop_pending = 1'b0;
        cyc++;
        empty_s   = (fifo_q.size() == 0) || (gap_mode != 0 && $urandom_range(0, 1) == 1);
        fifo_data = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        ready_s   = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
        empty0 = (sel != 0) || empty_s;
        empty1 = (sel != 1) || empty_s;
        ready0 = (sel == 0) && ready_s;
        ready1 = (sel == 1) && ready_s;
        #1;
        if (rst_n) begin
            if (rd_en_sel && empty_sel) pop_viol++;
            pop_pending = rd_en_sel && !empty_sel;
            if (prev_stall && (!valid_sel || wdata_sel !== prev_data)) stall_viol++;
            prev_stall = valid_sel && !ready_sel;
            prev_data  = wdata_sel;
            if (valid_sel && ready_sel) got_q.push_back(wdata_sel);
            if (busy_sel) busy_seen = 1'b1;
            if (done_sel) begin
                frame_cnt++;
                if (frame_cnt == 1) first_done_qsz = fifo_q.size();
            end
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    task automatic wait_frames(input string tag, input int n);
        int k;
        k = 0;
        while (frame_cnt < n && k < 4000) begin
            tick();
            k++;
        end
        repeat (8) tick();
        check_eq({tag, "_frame_done_count"}, WINW'(frame_cnt), WINW'(n));
    endtask

    task automatic compare_seq(input string tag);
        check_eq({tag, "_window_count"}, WINW'(got_q.size()), WINW'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_win%0d", tag, i), got_q[i], exp_q[i]);
        check_eq({tag, "_pop_while_empty"}, WINW'(pop_viol), WINW'(0));
        check_eq({tag, "_stall_unstable"}, WINW'(stall_viol), WINW'(0));
    endtask

    task automatic run_single(input string tag, input int s, input int g, input int rm);
        clear_board();
        sel = (s == 2) ? 1 : 0;
        gap_mode = g; ready_mode = rm;
        push_frame(0);
        expect_frame(s, 0);
        wait_frames(tag, 1);
        compare_seq(tag);
        check_eq({tag, "_busy_seen"}, WINW'(busy_seen), WINW'(1));
        check_eq({tag, "_busy_after"}, WINW'(busy_sel), WINW'(0));
    endtask

    initial begin
        rst_n = 1'b0; sel = 0; gap_mode = 0; ready_mode = 0; cyc = 0;
        pop_pending = 1'b0; fifo_data = '0; prev_data = '0; dummy_pix = '0;
        empty0 = 1'b1; empty1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0;
        empty_s = 1'b1; ready_s = 1'b0;
        clear_board();
        #1;
        check_eq("rst_valid", WINW'(valid0), WINW'(0));
        check_eq("rst_data", wdata0, WINW'(0));
        check_eq("rst_done", WINW'(done0), WINW'(0));
        check_eq("rst_busy", WINW'(busy0), WINW'(0));
        check_eq("rst_rd_en", WINW'(rd_en0), WINW'(0));
        repeat (3) tick();
        rst_n = 1'b1;

        // T1 defaults plus spot elements of window (0,0)
        run_single("t1", 1, 0, 0);
        if (got_q.size() > 0) begin
            check_eq("t1_e011", WINW'(elem_of(got_q[0], 0, 1, 1)), WINW'(8'h00));
            check_eq("t1_e022", WINW'(elem_of(got_q[0], 0, 2, 2)), WINW'(8'h11));
            check_eq("t1_e000", WINW'(elem_of(got_q[0], 0, 0, 0)), WINW'(8'h00));
            check_eq("t1_e222", WINW'(elem_of(got_q[0], 2, 2, 2)), WINW'(8'h91));
        end

        // T3 backpressure, T4 FIFO gaps
        run_single("t3", 1, 0, 1);
        run_single("t4", 1, 1, 0);

        // T5 two frames back-to-back
        clear_board();
        sel = 0; gap_mode = 0; ready_mode = 0;
        push_frame(0);
        push_frame(1);
        expect_frame(1, 0);
        expect_frame(1, 1);
        wait_frames("t5", 2);
        compare_seq("t5");
        check_eq("t5_no_early_pop", WINW'(first_done_qsz), WINW'(W * H));

        // T6 reset in the middle of emission, then a clean frame
        clear_board();
        push_frame(0);
        for (int k = 0; k < 2000 && got_q.size() < 10; k++) tick();
        check_eq("t6_reached_win10", WINW'(got_q.size() >= 10), WINW'(1));
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid_async", WINW'(valid0), WINW'(0));
        check_eq("t6_rd_en_async", WINW'(rd_en0), WINW'(0));
        fifo_q.delete();
        pop_pending = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        run_single("t6", 1, 0, 0);

        // T2 stride 2 on the second instance
        run_single("t2", 2, 0, 0);
        if (got_q.size() > 4) begin
            check_eq("t2_w11_e000", WINW'(elem_of(got_q[4], 0, 0, 0)), WINW'(8'h11));
        end
        if (got_q.size() > 8) begin
            check_eq("t2_w22_e000", WINW'(elem_of(got_q[8], 0, 0, 0)), WINW'(8'h33));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
